uart_hex_cmd_rx: RTL

//  Host-to-board command path: UART receiver plus ASCII-hex line parser.

---
 rtl/uart_hex_cmd_rx.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_hex_cmd_rx.sv
// uart_hex_cmd_rx
//   Host-to-board command path: 8N1 UART receiver followed by an ASCII-hex
//   line parser. It decodes "W<aaaa> <dd>\r" (write) and "R<aaaa>\r" (read)
//   into one 16-bit address / 8-bit data request. The request is handed to
//   the RC2014 bus-side logic over a valid/ready handshake.
//
//   Build option: define HEX_LOWERCASE_EN to accept 'a'-'f' as hex digits
//   and 'w'/'r' as command letters. Without it, any lowercase letter is
//   rejected with parse_err.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (default 868 = 100 MHz / 115200), >= 4
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   reset      in   synchronous active-high reset
//   uart_rx    in   asynchronous serial input, idle high, LSB first
//   cmd_valid  out  decoded command pending, held until accepted
//   cmd_ready  in   consumer accepts when cmd_valid && cmd_ready
//   cmd_write  out  1 = write ('W'), 0 = read ('R')
//   cmd_addr   out  16-bit address, first digit is [15:12]
//   cmd_data   out  8-bit data (write only, 8'h00 for read)
//   parse_err  out  1-cycle pulse, character illegal for the parser state
//   frame_err  out  1-cycle pulse, stop bit sampled low
//   overrun    out  1-cycle pulse, byte received while a command is pending
module uart_hex_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_data,
  output logic        parse_err,
  output logic        frame_err,
  output logic        overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    P_IDLE,
    P_ADDR,
    P_SEP,
    P_DATA,
    P_EOL,
    P_HOLD
  } p_state_t;

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  rx_state_t      rx_state;
  logic [1:0]     sync_q;
  logic           rx_prev;
  logic [CW-1:0]  bit_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift_q;
  logic           byte_stb;
  logic [7:0]     rx_byte;
  logic           rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= 2'b11;
      rx_prev   <= 1'b1;
      rx_state  <= RX_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      byte_stb  <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], uart_rx};
      rx_prev   <= rx_s;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          // Edge, not level: after a bad stop bit the line may still be low.
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == FULL_LAST) begin
            bit_cnt <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (bit_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_cnt == FULL_LAST) begin
            bit_cnt  <= '0;
            rx_state <= RX_IDLE;
            if (rx_s) begin
              byte_stb <= 1'b1;
              rx_byte  <= shift_q;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Character classification
  // ---------------------------------------------------------------------------
  logic       hex_ok;
  logic [3:0] hex_val;
  logic       is_w;
  logic       is_r;
  logic       is_cr;
  logic       is_lf;
  logic       is_space;

  always_comb begin
    hex_ok  = 1'b0;
    hex_val = '0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      hex_ok  = 1'b1;
      hex_val = rx_byte[3:0];
    end else if (rx_byte >= 8'h41 && rx_byte <= 8'h46) begin
      // 'A'..'F' have low nibble 1..6
      hex_ok  = 1'b1;
      hex_val = rx_byte[3:0] + 4'd9;
    end
`ifdef HEX_LOWERCASE_EN
    else if (rx_byte >= 8'h61 && rx_byte <= 8'h66) begin
      hex_ok  = 1'b1;
      hex_val = rx_byte[3:0] + 4'd9;
    end
`endif
  end

`ifdef HEX_LOWERCASE_EN
  assign is_w = (rx_byte == 8'h57) || (rx_byte == 8'h77);
  assign is_r = (rx_byte == 8'h52) || (rx_byte == 8'h72);
`else
  assign is_w = (rx_byte == 8'h57);
  assign is_r = (rx_byte == 8'h52);
`endif
  assign is_cr    = (rx_byte == 8'h0D);
  assign is_lf    = (rx_byte == 8'h0A);
  assign is_space = (rx_byte == 8'h20);

  // ---------------------------------------------------------------------------
  // Line parser
  // ---------------------------------------------------------------------------
  p_state_t   p_state;
  logic [1:0] digit_cnt;
  logic       char_bad;

  always_comb begin
    char_bad = 1'b0;
    case (p_state)
      P_IDLE:         char_bad = !(is_w || is_r || is_cr || is_lf);
      P_ADDR, P_DATA: char_bad = !hex_ok;
      P_SEP:          char_bad = !is_space;
      P_EOL:          char_bad = !is_cr;
      default:        char_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_state   <= P_IDLE;
      digit_cnt <= '0;
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      parse_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      parse_err <= 1'b0;
      overrun   <= 1'b0;
      if (p_state == P_HOLD) begin
        // Bytes arriving while a command is pending are dropped, including
        // one that lands in the accept cycle.
        if (byte_stb) begin
          overrun <= 1'b1;
        end
        if (cmd_valid && cmd_ready) begin
          cmd_valid <= 1'b0;
          p_state   <= P_IDLE;
        end
      end else if (byte_stb && char_bad) begin
        parse_err <= 1'b1;
        p_state   <= P_IDLE;
        digit_cnt <= '0;
        cmd_addr  <= '0;
        cmd_data  <= '0;
      end else if (byte_stb) begin
        case (p_state)
          P_IDLE: begin
            if (is_w || is_r) begin
              p_state   <= P_ADDR;
              cmd_write <= is_w;
              cmd_addr  <= '0;
              cmd_data  <= '0;
              digit_cnt <= '0;
            end
          end
          P_ADDR: begin
            cmd_addr <= {cmd_addr[11:0], hex_val};
            if (digit_cnt == 2'd3) begin
              digit_cnt <= '0;
              p_state   <= cmd_write ? P_SEP : P_EOL;
            end else begin
              digit_cnt <= digit_cnt + 1'b1;
            end
          end
          P_SEP: p_state <= P_DATA;
          P_DATA: begin
            cmd_data <= {cmd_data[3:0], hex_val};
            if (digit_cnt == 2'd1) begin
              digit_cnt <= '0;
              p_state   <= P_EOL;
            end else begin
              digit_cnt <= digit_cnt + 1'b1;
            end
          end
          P_EOL: begin
            p_state   <= P_HOLD;
            cmd_valid <= 1'b1;
          end
          default: p_state <= P_IDLE;
        endcase
      end
    end
  end

endmodule
